interp_2d_engine: RTL and testbench
===================================

INTERP_2D_ENGINE -- requirements
Module: interp_2d_engine

Interface
REQ-001 Parameter LANES, default 4: output samples per row, one filter lane each.
REQ-002 Parameter TAPS, default 6: filter taps per dimension; even, >= 2.
REQ-003 Parameter BLK_H, default 4: output rows per block.
REQ-004 Parameter IN_W, default 8: unsigned input/output sample width.
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 START  in  1  one-cycle block request; ignored unless state IDLE.
REQ-008 FRAC_X, FRAC_Y  in  4 each  horizontal/vertical phase 0..15; sampled on accepted START.
REQ-009 IN_VALID  in  1; IN_READY  out  1  input row handshake.
REQ-010 IN_ROW  in  (LANES+TAPS-1)*IN_W  reference row; sample 0 in MSBs.
REQ-011 OUT_VALID  out  1; OUT_READY  in  1  output row handshake.
REQ-012 OUT_ROW  out  LANES*IN_W  interpolated row; lane 0 in MSBs.
REQ-013 OUT_LAST  out  1  high with OUT_VALID on row BLK_H-1.
REQ-014 BUSY  out  1  state not IDLE; DONE  out  1  one-cycle pulse at block completion.

Function
REQ-015 States IDLE, LOAD, VFILT; IDLE->LOAD on START; LOAD->VFILT after ROWS = BLK_H+TAPS-1 rows accepted; VFILT->IDLE on acceptance of last output row, DONE high that cycle.
REQ-016 IN_READY high only in LOAD; row accepted when IN_VALID and IN_READY; IN_VALID outside LOAD ignored.
REQ-017 Pass 1: each accepted row, lane l = sum over k of COEF[FRAC_X][k] * IN_ROW sample (l+k), full precision, signed MID_W = IN_W+8 bits, no shift; written to buffer row index = acceptance count.
REQ-018 Pass 2: output row r, lane l = sum over k of COEF[FRAC_Y][k] * buffer[r+k][l]; add 2048, arithmetic shift right 12, clip to [0, 2^IN_W-1].
REQ-019 Output register loads next row when OUT_VALID low or OUT_READY high; throughput one row per cycle with OUT_READY held high.
REQ-020 Last input row accepted in cycle T: VFILT from T+1, first OUT_VALID in T+2.
REQ-021 OUT_VALID low: OUT_ROW/OUT_LAST hold; OUT_VALID high: OUT_ROW, OUT_LAST stable until accepted.
REQ-022 START while BUSY ignored; FRAC_X/FRAC_Y changes after START have no effect on the block in progress.
REQ-023 Row and output counters clear at each START; no wrap within a block; counters never exceed ROWS-1 / BLK_H-1.
REQ-024 Phase 0 = identity: output equals input sample (TAPS/2-1) offsets, bit-exact.

Reset
REQ-025 RST high: state IDLE, counters 0, IN_READY 0, OUT_VALID 0, OUT_LAST 0, OUT_ROW 0, BUSY 0, DONE 0.
REQ-026 RST mid-block aborts immediately; no DONE; buffer contents don't-care; next START begins a clean block.

Structure
REQ-027 Package interp_pkg holds COEF table [16][TAPS] signed 8-bit (each phase sums to 64; phase 0 = 64 at tap TAPS/2-1, else 0; phase 8 = {3,-11,40,40,-11,3}), rounding/shift constants, state enum.
REQ-028 One sub-module interp_fir: combinational TAPS-tap signed MAC, parameterised input width, instantiated LANES times per pass.
REQ-029 Buffer: ROWS x LANES registers of MID_W bits, no memory macro.

Verification
REQ-030 Reset, START with FRAC_X=FRAC_Y=0, 9 rows with IN_ROW sample j = 10*rowindex+j, OUT_READY=1 -> rows r lane l = 10*(r+2)+(l+2), OUT_LAST on row 3, DONE one cycle after.
REQ-031 Constant input 100, FRAC_X=FRAC_Y=8 -> all 16 outputs 100; first OUT_VALID exactly 2 cycles after last input acceptance.
REQ-032 Input step 0/255 across samples, phase 8 -> overshoot results clipped to 255, undershoot to 0.
REQ-033 OUT_READY toggled pseudo-randomly and IN_VALID gapped -> no row lost/duplicated, OUT_ROW stable while stalled.
REQ-034 RST asserted mid-VFILT after 2 output rows -> next cycle all outputs zero, no DONE; subsequent block correct.
REQ-035 START pulsed during LOAD with different FRAC values -> ignored; results match original FRAC.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared definitions for the 2-D interpolation engine: FSM states, rounding
// constants and the 16-phase signed coefficient table.
`timescale 1ns/1ps
package interp_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_VFILT = 2'd2
   } state_t;

   localparam int COEF_W = 8;
   localparam int RND    = 2048;
   localparam int SHIFT  = 12;

   // Every phase sums to 64; phases 9..15 mirror phases 7..1.
   localparam logic signed [7:0] COEF [16][6] = '{
      '{ 8'sd0,   8'sd0,   8'sd64,  8'sd0,   8'sd0,   8'sd0 },
      '{ 8'sd0,  -8'sd2,   8'sd63,  8'sd4,  -8'sd1,   8'sd0 },
      '{ 8'sd1,  -8'sd4,   8'sd62,  8'sd7,  -8'sd3,   8'sd1 },
      '{ 8'sd1,  -8'sd5,   8'sd59,  8'sd12, -8'sd4,   8'sd1 },
      '{ 8'sd2,  -8'sd7,   8'sd56,  8'sd17, -8'sd6,   8'sd2 },
      '{ 8'sd2,  -8'sd8,   8'sd52,  8'sd22, -8'sd7,   8'sd3 },
      '{ 8'sd2,  -8'sd9,   8'sd48,  8'sd28, -8'sd9,   8'sd4 },
      '{ 8'sd3,  -8'sd10,  8'sd44,  8'sd34, -8'sd10,  8'sd3 },
      '{ 8'sd3,  -8'sd11,  8'sd40,  8'sd40, -8'sd11,  8'sd3 },
      '{ 8'sd3,  -8'sd10,  8'sd34,  8'sd44, -8'sd10,  8'sd3 },
      '{ 8'sd4,  -8'sd9,   8'sd28,  8'sd48, -8'sd9,   8'sd2 },
      '{ 8'sd3,  -8'sd7,   8'sd22,  8'sd52, -8'sd8,   8'sd2 },
      '{ 8'sd2,  -8'sd6,   8'sd17,  8'sd56, -8'sd7,   8'sd2 },
      '{ 8'sd1,  -8'sd4,   8'sd12,  8'sd59, -8'sd5,   8'sd1 },
      '{ 8'sd1,  -8'sd3,   8'sd7,   8'sd62, -8'sd4,   8'sd1 },
      '{ 8'sd0,  -8'sd1,   8'sd4,   8'sd63, -8'sd2,   8'sd0 }
   };

   // Non-6-tap builds fall back to a two-tap linear kernel centred the same way.
   function automatic logic signed [7:0] coef(input logic [3:0] ph, input int k, input int taps);
      int w;
      if (taps == 6) begin
         return COEF[ph][3'(k)];
      end
      if (k == taps / 2 - 1) begin
         w = 64 - 4 * int'(ph);
      end else if (k == taps / 2) begin
         w = 4 * int'(ph);
      end else begin
         w = 0;
      end
      return 8'(w);
   endfunction

endpackage

// File: rtl/interp_fir.sv
// Combinational TAPS-tap signed multiply-accumulate used by both filter passes.
`timescale 1ns/1ps
module interp_fir #(
   parameter int TAPS = 6,
   parameter int DW   = 9,
   parameter int OW   = DW + 8 + $clog2(TAPS)
) (
   input  logic signed [DW-1:0] samples [TAPS],
   input  logic signed [7:0]    coefs   [TAPS],
   output logic signed [OW-1:0] acc
);

   always_comb begin
      acc = '0;
      for (int k = 0; k < TAPS; k++) begin
         acc = acc + OW'(samples[k]) * OW'(coefs[k]);
      end
   end

endmodule

// File: rtl/interp_2d_engine.sv
// Separable 2-D interpolator: rows are filtered horizontally as they arrive,
// buffered at full precision, then filtered vertically into output rows.
`timescale 1ns/1ps
module interp_2d_engine
   import interp_pkg::*;
#(
   parameter int LANES = 4,
   parameter int TAPS  = 6,
   parameter int BLK_H = 4,
   parameter int IN_W  = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [3:0]                     frac_x,
   input  logic [3:0]                     frac_y,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [(LANES+TAPS-1)*IN_W-1:0] in_row,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [LANES*IN_W-1:0]          out_row,
   output logic                           out_last,
   output logic                           busy,
   output logic                           done
);

   localparam int ROWS  = BLK_H + TAPS - 1;
   localparam int MID_W = IN_W + 8;
   localparam int ACC_W = MID_W + 8 + $clog2(TAPS);
   localparam int SW    = (LANES + TAPS - 1) * IN_W;
   localparam int CW    = $clog2(ROWS);
   localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(RND);
   localparam logic signed [ACC_W-1:0] TOP_C = ACC_W'((2 ** IN_W) << SHIFT);

   state_t                    state;
   logic [3:0]                fx;
   logic [3:0]                fy;
   logic [CW-1:0]             row_cnt;
   logic [CW-1:0]             out_cnt;
   logic                      last_issued;
   logic signed [MID_W-1:0]   buffer [ROWS][LANES];
   logic signed [7:0]         coef_x [TAPS];
   logic signed [7:0]         coef_y [TAPS];
   logic signed [MID_W-1:0]   h_acc  [LANES];
   logic signed [ACC_W-1:0]   v_acc  [LANES];
   logic [LANES*IN_W-1:0]     v_row;

   for (genvar k = 0; k < TAPS; k++) begin : g_coef
      assign coef_x[k] = coef(fx, k, TAPS);
      assign coef_y[k] = coef(fy, k, TAPS);
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [IN_W:0]    hs [TAPS];
      logic signed [MID_W-1:0] vs [TAPS];
      for (genvar k = 0; k < TAPS; k++) begin : g_tap
         assign hs[k] = {1'b0, in_row[SW-1-(l+k)*IN_W -: IN_W]};
         assign vs[k] = buffer[out_cnt + CW'(k)][l];
      end
      interp_fir #(.TAPS(TAPS), .DW(IN_W + 1), .OW(MID_W)) u_hfir (
         .samples(hs), .coefs(coef_x), .acc(h_acc[l])
      );
      interp_fir #(.TAPS(TAPS), .DW(MID_W), .OW(ACC_W)) u_vfir (
         .samples(vs), .coefs(coef_y), .acc(v_acc[l])
      );
   end

   // Round, shift by 12 and clip each vertical result to the sample range.
   always_comb begin
      logic signed [ACC_W-1:0] rnd_v;
      v_row = '0;
      for (int l = 0; l < LANES; l++) begin
         rnd_v = v_acc[l] + RND_C;
         if (rnd_v[ACC_W-1]) begin
            v_row[(LANES-1-l)*IN_W +: IN_W] = '0;
         end else if (rnd_v >= TOP_C) begin
            v_row[(LANES-1-l)*IN_W +: IN_W] = '1;
         end else begin
            v_row[(LANES-1-l)*IN_W +: IN_W] = rnd_v[SHIFT+IN_W-1:SHIFT];
         end
      end
   end

   // Pass-1 results land in the buffer row addressed by the acceptance count.
   always_ff @(posedge clk) begin
      if (state == S_LOAD && in_valid) begin
         for (int l = 0; l < LANES; l++) begin
            buffer[row_cnt][l] <= h_acc[l];
         end
      end
   end

   // Block FSM with registered handshake, output row and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         fx          <= 4'd0;
         fy          <= 4'd0;
         row_cnt     <= '0;
         out_cnt     <= '0;
         last_issued <= 1'b0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         out_row     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_LOAD;
                  fx          <= frac_x;
                  fy          <= frac_y;
                  row_cnt     <= '0;
                  out_cnt     <= '0;
                  last_issued <= 1'b0;
                  in_ready    <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            S_LOAD: begin
               if (in_valid && in_ready) begin
                  if (row_cnt == CW'(ROWS - 1)) begin
                     state    <= S_VFILT;
                     in_ready <= 1'b0;
                  end else begin
                     row_cnt <= row_cnt + CW'(1);
                  end
               end
            end
            S_VFILT: begin
               // Output slot frees up when empty or being taken this cycle.
               if (!out_valid || out_ready) begin
                  if (!last_issued) begin
                     out_valid <= 1'b1;
                     out_row   <= v_row;
                     out_last  <= (out_cnt == CW'(BLK_H - 1));
                     if (out_cnt == CW'(BLK_H - 1)) begin
                        last_issued <= 1'b1;
                     end else begin
                        out_cnt <= out_cnt + CW'(1);
                     end
                  end else begin
                     out_valid <= 1'b0;
                  end
               end
               if (out_valid && out_ready && out_last) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_interp_2d_engine.sv
// Randomised scoreboard bench for interp_2d_engine against a plain-arithmetic
// separable filter model.
`timescale 1ns/1ps
module tb_interp_2d_engine;

   localparam int LANES = 4;
   localparam int TAPS  = 6;
   localparam int BLK_H = 4;
   localparam int IN_W  = 8;
   localparam int ROWS  = BLK_H + TAPS - 1;
   localparam int NS    = LANES + TAPS - 1;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   start;
   logic [3:0]             frac_x;
   logic [3:0]             frac_y;
   logic                   in_valid;
   logic                   in_ready;
   logic [NS*IN_W-1:0]     in_row;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*IN_W-1:0]  out_row;
   logic                   out_last;
   logic                   busy;
   logic                   done;

   typedef struct packed {
      logic [LANES*IN_W-1:0] row;
      logic                  last;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   acc_rows = 0;
   bit   exp_done = 1'b0;
   bit   rdy_rand = 1'b0;
   int   in_s [ROWS][NS];

   int C [16][TAPS] = '{
      '{0, 0, 64, 0, 0, 0},      '{0, -2, 63, 4, -1, 0},
      '{1, -4, 62, 7, -3, 1},    '{1, -5, 59, 12, -4, 1},
      '{2, -7, 56, 17, -6, 2},   '{2, -8, 52, 22, -7, 3},
      '{2, -9, 48, 28, -9, 4},   '{3, -10, 44, 34, -10, 3},
      '{3, -11, 40, 40, -11, 3}, '{3, -10, 34, 44, -10, 3},
      '{4, -9, 28, 48, -9, 2},   '{3, -7, 22, 52, -8, 2},
      '{2, -6, 17, 56, -7, 2},   '{1, -4, 12, 59, -5, 1},
      '{1, -3, 7, 62, -4, 1},    '{0, -1, 4, 63, -2, 0}
   };

   interp_2d_engine #(.LANES(LANES), .TAPS(TAPS), .BLK_H(BLK_H), .IN_W(IN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .frac_x(frac_x), .frac_y(frac_y),
      .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
   endtask

   function automatic logic [NS*IN_W-1:0] pack(input int r);
      logic [NS*IN_W-1:0] v;
      v = '0;
      for (int j = 0; j < NS; j++) v[(NS-1-j)*IN_W +: IN_W] = 8'(in_s[r][j]);
      return v;
   endfunction

   // Reference: 2-D separable filter written as direct sums, then round and clip.
   function automatic void model_push(input int fx, input int fy);
      logic [LANES*IN_W-1:0] row;
      int acc, h, v;
      for (int r = 0; r < BLK_H; r++) begin
         row = '0;
         for (int l = 0; l < LANES; l++) begin
            acc = 0;
            for (int ky = 0; ky < TAPS; ky++) begin
               h = 0;
               for (int kx = 0; kx < TAPS; kx++) h += C[fx][kx] * in_s[r+ky][l+kx];
               acc += C[fy][ky] * h;
            end
            v = (acc + 2048) >>> 12;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            row[(LANES-1-l)*IN_W +: IN_W] = 8'(v);
         end
         q.push_back('{row: row, last: (r == BLK_H - 1)});
      end
   endfunction

   // Output-ready driver: held high or toggled randomly.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   // Monitor: pops the scoreboard on every accepted row, checks stall stability and DONE.
   initial begin
      bit                    held_v = 1'b0;
      bit                    done_next;
      logic [LANES*IN_W-1:0] held_row;
      logic                  held_last;
      exp_t                  e;
      forever begin
         @(negedge clk);
         if (rst) begin
            held_v   = 1'b0;
            exp_done = 1'b0;
         end else begin
            if (done || exp_done) chk("done_pulse", {63'd0, done}, {63'd0, exp_done});
            done_next = 1'b0;
            if (held_v && out_valid) begin
               chk("stall_row_hold", {32'd0, out_row}, {32'd0, held_row});
               chk("stall_last_hold", {63'd0, out_last}, {63'd0, held_last});
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  chk("unexpected_row", {32'd0, out_row}, 64'd0);
                  n_err += (out_row == '0) ? 1 : 0;
               end else begin
                  e = q.pop_front();
                  chk("out_row", {32'd0, out_row}, {32'd0, e.row});
                  chk("out_last", {63'd0, out_last}, {63'd0, e.last});
                  done_next = e.last;
               end
               acc_rows++;
               held_v = 1'b0;
            end else if (out_valid) begin
               held_v    = 1'b1;
               held_row  = out_row;
               held_last = out_last;
            end else begin
               held_v = 1'b0;
            end
            exp_done = done_next;
         end
      end
   end

   // kind: 0 random, 1 ramp 10*r+j, 2 constant 100, 3 horizontal/vertical 0/255 steps
   task automatic run_block(input int fx, input int fy, input int kind, input bit gap,
                            input bit glitch, input bit abort);
      int r, budget, lat, sp, base;
      bit acc;
      logic [LANES*IN_W-1:0] row;
      for (int rr = 0; rr < ROWS; rr++) begin
         sp = $urandom_range(1, NS - 1);
         for (int j = 0; j < NS; j++) begin
            case (kind)
               1: in_s[rr][j] = 10 * rr + j;
               2: in_s[rr][j] = 100;
               3: in_s[rr][j] = ((j >= sp) ^ (rr >= ROWS / 2)) ? 255 : 0;
               default: in_s[rr][j] = $urandom_range(0, 255);
            endcase
         end
      end
      if (kind == 1) begin
         for (int rr = 0; rr < BLK_H; rr++) begin
            for (int l = 0; l < LANES; l++) row[(LANES-1-l)*IN_W +: IN_W] = 8'(10 * (rr + 2) + l + 2);
            q.push_back('{row: row, last: (rr == BLK_H - 1)});
         end
      end else begin
         model_push(fx, fy);
      end
      start    = 1'b1;
      frac_x   = 4'(fx);
      frac_y   = 4'(fy);
      in_valid = 1'b1;
      in_row   = {$urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      start  = 1'b0;
      frac_x = 4'($urandom);
      frac_y = 4'($urandom);
      r = 0;
      budget = 0;
      base = acc_rows;
      while (r < ROWS && budget < 500) begin
         in_valid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_row   = pack(r);
         if (glitch && r == 3) begin
            start  = 1'b1;
            frac_x = 4'(fx ^ 7);
            frac_y = 4'(fy ^ 9);
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         start = 1'b0;
         budget++;
         if (acc) r++;
      end
      in_valid = 1'b0;
      if (r < ROWS) timeout_fail("input_accept");
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("first_out_latency", 64'(lat), 64'd2);
      if (abort) begin
         budget = 0;
         while (acc_rows < base + 2 && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
         end
         if (budget >= 200) timeout_fail("abort_wait");
         rst = 1'b1;
         q.delete();
         exp_done = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
         chk("abort_out_row", {32'd0, out_row}, 64'd0);
         chk("abort_out_last", {63'd0, out_last}, 64'd0);
         chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
         chk("abort_busy", {63'd0, busy}, 64'd0);
         chk("abort_done", {63'd0, done}, 64'd0);
         @(posedge clk);
         #1;
         rst = 1'b0;
      end else begin
         budget = 0;
         while (budget < 300) begin
            @(negedge clk);
            if (!busy) break;
            budget++;
         end
         if (budget >= 300) timeout_fail("block_complete");
         chk("queue_drained", 64'(q.size()), 64'd0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      frac_x   = 4'd0;
      frac_y   = 4'd0;
      in_valid = 1'b0;
      in_row   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_last", {63'd0, out_last}, 64'd0);
      chk("rst_out_row", {32'd0, out_row}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_block(0, 0, 1, 1'b0, 1'b0, 1'b0);
      run_block(8, 8, 2, 1'b0, 1'b0, 1'b0);
      run_block(8, 8, 3, 1'b0, 1'b0, 1'b0);
      run_block(8, 8, 3, 1'b1, 1'b0, 1'b0);
      rdy_rand = 1'b1;
      for (int b = 0; b < 6; b++) begin
         run_block($urandom_range(0, 15), $urandom_range(0, 15), 0, 1'b1, 1'b0, 1'b0);
      end
      run_block($urandom_range(0, 15), $urandom_range(0, 15), 0, 1'b1, 1'b0, 1'b1);
      run_block($urandom_range(0, 15), $urandom_range(0, 15), 0, 1'b1, 1'b0, 1'b0);
      run_block(5, 11, 0, 1'b0, 1'b1, 1'b0);
      rdy_rand = 1'b0;
      run_block(0, 0, 0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
